// File: rtl/result_7seg_driver_if.sv
// Result handshake between the calc datapath (producer) and the 7-segment driver (consumer).
// result_valid is a one-cycle pulse. result is only meaningful while result_valid is high.
interface result_7seg_driver_if;
   logic       result_valid;
   logic [3:0] result;

   modport master (
      output result_valid,
      output result
   );

   modport slave (
      input result_valid,
      input result
   );
endinterface

// File: rtl/result_7seg_driver.sv
// result_7seg_driver: captures a 4-bit result on its finish pulse and shows it on a
// time-multiplexed 2-digit 7-segment display (an[0] = units, an[1] = sign/tens).
// Build option: define SIGNED_DISP_EN to show the result as two's complement (-8..+7)
// with a minus sign. Leave it undefined to show 0..15 with a suppressed leading tens digit.
// Pipeline: value_q at capture edge N, digit patterns at N+1, seg/an pins at N+2.
module result_7seg_driver #(
   parameter int unsigned REFRESH_W      = 16,
   parameter int unsigned REFRESH_MAX    = 49999,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   result_7seg_driver_if.slave bus,
   output logic [6:0]          seg,
   output logic [1:0]          an,
   output logic                disp_valid
);

   // Active-high gfedcba patterns
   localparam logic [6:0] PatMinus = 7'h40;
   localparam logic [6:0] PatBlank = 7'h00;

   localparam logic [REFRESH_W-1:0] RefreshLast = REFRESH_W'(REFRESH_MAX);

   // Pin levels for "everything off"
   localparam logic [6:0] SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0] AnOff  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

   typedef enum logic {
      StBlank,
      StShow
   } state_e;

   state_e               state_q;
   logic [3:0]           value_q;
   logic                 disp_valid_q;

   logic [REFRESH_W-1:0] refresh_cnt_q;
   logic                 dig_sel_q;
   logic                 refresh_wrap;

   logic [6:0]           dig0_d, dig1_d;
   logic [6:0]           dig0_q, dig1_q;
   // Tracks state one cycle late so the pins light only once the digit regs hold real data
   logic                 show_q;

   logic [6:0]           seg_q;
   logic [1:0]           an_q;

   function automatic logic [6:0] digit_pattern(input logic [4:0] d);
      logic [6:0] p;
      case (d)
         5'd0:    p = 7'h3F;
         5'd1:    p = 7'h06;
         5'd2:    p = 7'h5B;
         5'd3:    p = 7'h4F;
         5'd4:    p = 7'h66;
         5'd5:    p = 7'h6D;
         5'd6:    p = 7'h7D;
         5'd7:    p = 7'h07;
         5'd8:    p = 7'h7F;
         5'd9:    p = 7'h6F;
         default: p = PatBlank;
      endcase
      return p;
   endfunction

   function automatic logic [6:0] seg_pin(input logic [6:0] p);
      return SEG_ACTIVE_LOW ? ~p : p;
   endfunction

   function automatic logic [1:0] an_pin(input logic [1:0] a);
      return SEG_ACTIVE_LOW ? ~a : a;
   endfunction

   // Display FSM: BLANK until the first result, then SHOW until reset; captures every result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StBlank;
         value_q      <= 4'd0;
         disp_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StBlank: begin
               if (bus.result_valid) begin
                  state_q      <= StShow;
                  value_q      <= bus.result;
                  disp_valid_q <= 1'b1;
               end
            end
            StShow: begin
               if (bus.result_valid) begin
                  value_q <= bus.result;
               end
               disp_valid_q <= 1'b1;
            end
            default: begin
               state_q      <= StBlank;
               disp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign refresh_wrap = (refresh_cnt_q == RefreshLast);

   // Free-running refresh divider. Runs in both states. dig_sel flips on each wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt_q <= '0;
         dig_sel_q     <= 1'b0;
      end else if (refresh_wrap) begin
         refresh_cnt_q <= '0;
         dig_sel_q     <= ~dig_sel_q;
      end else begin
         refresh_cnt_q <= refresh_cnt_q + REFRESH_W'(1);
      end
   end

`ifdef SIGNED_DISP_EN
   logic [4:0] mag;

   // Signed digits: 5-bit negate so -8 maps to +8. The tens position is only ever a sign.
   always_comb begin
      mag = {value_q[3], value_q};
      if (value_q[3]) begin
         mag = 5'd0 - {value_q[3], value_q};
      end
      dig0_d = digit_pattern(mag);
      dig1_d = value_q[3] ? PatMinus : PatBlank;
   end
`else
   logic [3:0] units;
   logic       has_tens;

   // Unsigned digits 0..15. A zero tens digit is blanked.
   always_comb begin
      has_tens = (value_q >= 4'd10);
      units    = has_tens ? (value_q - 4'd10) : value_q;
      dig0_d   = digit_pattern({1'b0, units});
      dig1_d   = has_tens ? digit_pattern(5'd1) : PatBlank;
   end
`endif

   // Digit decode stage, one cycle behind value_q
   always_ff @(posedge clk) begin
      if (rst) begin
         dig0_q <= PatBlank;
         dig1_q <= PatBlank;
         show_q <= 1'b0;
      end else begin
         dig0_q <= dig0_d;
         dig1_q <= dig1_d;
         show_q <= (state_q == StShow);
      end
   end

   // Pin stage: exactly one anode on while showing, all off while blank
   always_ff @(posedge clk) begin
      if (rst || !show_q) begin
         seg_q <= SegOff;
         an_q  <= AnOff;
      end else if (dig_sel_q) begin
         seg_q <= seg_pin(dig1_q);
         an_q  <= an_pin(2'b10);
      end else begin
         seg_q <= seg_pin(dig0_q);
         an_q  <= an_pin(2'b01);
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_result_7seg_driver.sv
// Bench for result_7seg_driver: a behavioural display model compared every cycle, plus
// literal digit expectations and randomized result/reset traffic.
module tb_result_7seg_driver;
   localparam int unsigned RW = 4;
   localparam int unsigned RM = 7;
   localparam int unsigned P  = RM + 1;

`ifdef SIGNED_DISP_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg;
   logic [1:0] an;
   logic       disp_valid;

   int checks = 0;
   int errors = 0;

   result_7seg_driver_if bus_if ();

   result_7seg_driver #(
      .REFRESH_W     (RW),
      .REFRESH_MAX   (RM),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .seg       (seg),
      .an        (an),
      .disp_valid(disp_valid)
   );

   always #5 clk = ~clk;

   // Digit codes: 0..9 numerals, 10 minus, 11 blank
   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         10: return 7'h40;
         default: return 7'h00;
      endcase
   endfunction

   function automatic int units_code(input int r);
      int s;
      if (SIGNED_BUILD) begin
         s = (r > 7) ? r - 16 : r;
         return (s < 0) ? -s : s;
      end
      return r % 10;
   endfunction

   function automatic int upper_code(input int r);
      if (SIGNED_BUILD) return (r > 7) ? 10 : 11;
      return (r / 10 == 1) ? 1 : 11;
   endfunction

   // Model state: k = clean edges since the last reset edge
   int         k = 0;
   int         m_val = 0, d_val = 0;
   bit         m_show = 0, d_show = 0;
   logic [6:0] e_seg = 7'h7F;
   logic [1:0] e_an = 2'b11;
   bit         e_dv = 0;
   bit         started = 0;

   always @(posedge clk) begin
      bit sel;
      if (rst) begin
         k = 0; m_val = 0; d_val = 0; m_show = 0; d_show = 0;
         e_seg = 7'h7F; e_an = 2'b11; e_dv = 0; started = 1;
      end else begin
         sel = ((k / P) % 2) == 1;
         if (d_show) begin
            e_seg = ~pat(sel ? upper_code(d_val) : units_code(d_val));
            e_an  = sel ? 2'b01 : 2'b10;
         end else begin
            e_seg = 7'h7F;
            e_an  = 2'b11;
         end
         d_val  = m_val;
         d_show = m_show;
         if (bus_if.result_valid) begin
            m_val  = int'(bus_if.result);
            m_show = 1;
         end
         k++;
         e_dv = m_show;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("seg", int'(seg), int'(e_seg));
         check("an", int'(an), int'(e_an));
         check("disp_valid", int'(disp_valid), int'(e_dv));
      end
   end

   task automatic pulse(input logic [3:0] r);
      bus_if.result_valid = 1'b1;
      bus_if.result       = r;
      @(negedge clk);
      bus_if.result_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic expect_digit(input string name, input logic [1:0] an_want,
                               input logic [6:0] seg_want);
      bit found = 0;
      for (int i = 0; i < 3 * P && !found; i++) begin
         @(negedge clk);
         if (an == an_want) found = 1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: an %0b never seen, want %0b", name, an, an_want);
      end else begin
         check(name, int'(seg), int'(seg_want));
      end
   endtask

   initial begin
      logic [6:0] u1, t1, u2, t2, u3, t3;
      bit aligned;
      bus_if.result_valid = 1'b0;
      bus_if.result       = 4'd0;
      if (SIGNED_BUILD) begin
         u1 = ~7'h4F; t1 = ~7'h40;   // 4'b1101 = -3
         u2 = ~7'h7F; t2 = ~7'h40;   // -8
         u3 = ~7'h07; t3 = 7'h7F;    // +7
      end else begin
         u1 = ~7'h4F; t1 = ~7'h06;   // 13
         u2 = ~7'h6F; t2 = 7'h7F;    // 8 -> shown via 9 below
         u3 = ~7'h07; t3 = 7'h7F;    // 7
      end

      // Reset then idle blank
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2 * P) @(negedge clk);
      check("idle_seg", int'(seg), 7'h7F);
      check("idle_an", int'(an), 2'b11);
      check("idle_dv", int'(disp_valid), 0);

      pulse(4'b1101);
      check("dv_after_first", int'(disp_valid), 1);
      expect_digit("r1101_units", 2'b10, u1);
      expect_digit("r1101_upper", 2'b01, t1);

      pulse(SIGNED_BUILD ? 4'b1000 : 4'd9);
      expect_digit("r2_units", 2'b10, u2);
      expect_digit("r2_upper", 2'b01, t2);

      pulse(4'b0111);
      expect_digit("r0111_units", 2'b10, u3);
      expect_digit("r0111_upper", 2'b01, t3);

      // Capture on the refresh wrap edge, then overwrite next cycle
      aligned = 0;
      for (int i = 0; i < 2 * P && !aligned; i++) begin
         if ((k % P) == RM) aligned = 1;
         else @(negedge clk);
      end
      checks++;
      if (!aligned) begin
         errors++;
         $display("FAIL wrap_align: k=%0d never reached terminal count", k);
      end
      bus_if.result_valid = 1'b1;
      bus_if.result       = 4'd5;
      @(negedge clk);
      bus_if.result       = 4'd2;
      @(negedge clk);
      bus_if.result_valid = 1'b0;
      repeat (2 * P) @(negedge clk);
      expect_digit("wrap_units", 2'b10, ~7'h5B);
      expect_digit("wrap_upper", 2'b01, 7'h7F);

      // Reset beats a coincident result while showing
      rst = 1'b1;
      bus_if.result_valid = 1'b1;
      bus_if.result       = 4'd9;
      @(negedge clk);
      rst = 1'b0;
      bus_if.result_valid = 1'b0;
      check("rst_dv", int'(disp_valid), 0);
      check("rst_seg", int'(seg), 7'h7F);
      check("rst_an", int'(an), 2'b11);
      repeat (P) @(negedge clk);
      check("rst_stays_blank", int'(an), 2'b11);
      pulse(4'd1);
      expect_digit("post_rst_units", 2'b10, ~7'h06);

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst                 = ($urandom_range(0, 199) == 0);
         bus_if.result_valid = ($urandom_range(0, 5) == 0);
         bus_if.result       = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      rst = 1'b0;
      bus_if.result_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
